riscv_fetch_ctrl: RTL and testbench

- Instruction-fetch sequencer between the program counter and instruction memory.
- Owns the fetch PC and drives a req/ack instruction-memory handshake.
- Applies execute-stage redirects (branch, jump, trap) and delivers fetched instructions to decode through a 1-entry output register and a 1-entry skid buffer.
- Absorbs decode back-pressure without losing or duplicating instructions.

---
 rtl/riscv_fetch_ctrl_if.sv | 24 ++
 rtl/riscv_fetch_ctrl.sv | 164 ++++++++++++++++
 tb/tb_riscv_fetch_ctrl.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_fetch_ctrl_if.sv
// Instruction-memory request/acknowledge bus between the fetch sequencer
// (master) and instruction memory (slave).
interface riscv_fetch_ctrl_if #(
    parameter int WORD_LENGTH = 32
);
    logic                   imem_req;
    logic [WORD_LENGTH-1:0] imem_addr;
    logic                   imem_ack;
    logic [WORD_LENGTH-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/riscv_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, runs the req/ack memory
// handshake, applies execute-stage redirects and hands instructions to
// decode through an output register backed by a one-entry skid buffer.
module riscv_fetch_ctrl #(
    parameter int                     WORD_LENGTH  = 32,
    parameter int                     PC_OFFSET    = 4,
    parameter logic [WORD_LENGTH-1:0] RESET_VECTOR = '0
) (
    input  logic                   clk,
    input  logic                   x_reset,
    riscv_fetch_ctrl_if.master     imem,
    input  logic                   redirect_valid,
    input  logic [WORD_LENGTH-1:0] redirect_addr,
    input  logic                   stall,
    output logic                   inst_valid,
    output logic [WORD_LENGTH-1:0] inst_out,
    output logic [WORD_LENGTH-1:0] inst_pc,
    output logic [WORD_LENGTH-1:0] inst_pc_plus4
);

    localparam logic [WORD_LENGTH-1:0] PC_INC = WORD_LENGTH'(PC_OFFSET);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic                   req_q, req_d;
    logic [WORD_LENGTH-1:0] addr_q, addr_d;
    logic [WORD_LENGTH-1:0] tgt_q, tgt_d;
    logic                   out_vld_q, out_vld_d;
    logic [WORD_LENGTH-1:0] out_inst_q, out_inst_d;
    logic [WORD_LENGTH-1:0] out_pc_q, out_pc_d;
    logic                   skid_vld_q, skid_vld_d;
    logic [WORD_LENGTH-1:0] skid_inst_q, skid_inst_d;
    logic [WORD_LENGTH-1:0] skid_pc_q, skid_pc_d;

    logic                   accept;
    logic                   consume;
    logic [WORD_LENGTH-1:0] target;
    logic                   unused_align_bits;

    assign accept  = req_q & imem.imem_ack;
    assign consume = out_vld_q & ~stall;
    // Redirect targets are forced to word alignment; the low bits are dropped.
    assign target  = {redirect_addr[WORD_LENGTH-1:2], 2'b00};
    assign unused_align_bits = ^redirect_addr[1:0];

    // Next-state, fetch-address and output/skid selection.
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        addr_d      = addr_q;
        tgt_d       = tgt_q;
        out_vld_d   = out_vld_q;
        out_inst_d  = out_inst_q;
        out_pc_d    = out_pc_q;
        skid_vld_d  = skid_vld_q;
        skid_inst_d = skid_inst_q;
        skid_pc_d   = skid_pc_q;

        if (redirect_valid) begin
            // Redirect wins over stall and ack: flush everything queued for decode.
            out_vld_d  = 1'b0;
            skid_vld_d = 1'b0;
            if (req_q && !imem.imem_ack) begin
                // Request still in flight: keep it stable and drop its data later.
                state_d = DRAIN;
                tgt_d   = target;
            end else begin
                state_d = FETCH;
                addr_d  = target;
                req_d   = 1'b1;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = FETCH;
                    req_d   = 1'b1;
                end
                FETCH: begin
                    if (skid_vld_q) begin
                        if (consume) begin
                            out_vld_d  = 1'b1;
                            out_inst_d = skid_inst_q;
                            out_pc_d   = skid_pc_q;
                            if (accept) begin
                                skid_inst_d = imem.imem_rdata;
                                skid_pc_d   = addr_q;
                            end else begin
                                skid_vld_d = 1'b0;
                            end
                        end
                    end else if (accept) begin
                        if (!out_vld_q || consume) begin
                            out_vld_d  = 1'b1;
                            out_inst_d = imem.imem_rdata;
                            out_pc_d   = addr_q;
                        end else begin
                            skid_vld_d  = 1'b1;
                            skid_inst_d = imem.imem_rdata;
                            skid_pc_d   = addr_q;
                        end
                    end else if (consume) begin
                        out_vld_d = 1'b0;
                    end
                    if (accept) begin
                        addr_d = addr_q + PC_INC;
                    end
                    // A pending request never has a full skid, so this also holds it.
                    req_d = ~skid_vld_d;
                end
                DRAIN: begin
                    if (imem.imem_ack) begin
                        state_d = FETCH;
                        addr_d  = tgt_q;
                        req_d   = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge x_reset) begin
        if (!x_reset) begin
            state_q     <= IDLE;
            req_q       <= 1'b0;
            addr_q      <= RESET_VECTOR;
            tgt_q       <= RESET_VECTOR;
            out_vld_q   <= 1'b0;
            out_inst_q  <= '0;
            out_pc_q    <= '0;
            skid_vld_q  <= 1'b0;
            skid_inst_q <= '0;
            skid_pc_q   <= '0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            addr_q      <= addr_d;
            tgt_q       <= tgt_d;
            out_vld_q   <= out_vld_d;
            out_inst_q  <= out_inst_d;
            out_pc_q    <= out_pc_d;
            skid_vld_q  <= skid_vld_d;
            skid_inst_q <= skid_inst_d;
            skid_pc_q   <= skid_pc_d;
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = addr_q;
    assign inst_valid     = out_vld_q;
    assign inst_out       = out_inst_q;
    assign inst_pc        = out_pc_q;
    assign inst_pc_plus4  = out_pc_q + PC_INC;

endmodule

// File: tb/tb_riscv_fetch_ctrl.sv
// Testbench for riscv_fetch_ctrl: directed stimulus plus a stream-level
// reference model (queue of fetched-but-undelivered addresses).
module tb_riscv_fetch_ctrl;

    localparam logic [31:0] KEY = 32'hA5A5A5A5;
    localparam logic [31:0] RV  = 32'h0;

    logic        clk;
    logic        x_reset;
    logic        redirect_valid;
    logic [31:0] redirect_addr;
    logic        stall;
    logic        inst_valid;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic [31:0] inst_pc_plus4;
    logic        zw;
    logic        ack_man;

    riscv_fetch_ctrl_if #(.WORD_LENGTH(32)) bus ();

    // Memory: zero-wait (ack follows req) or manually acked; data = addr ^ KEY.
    assign bus.imem_ack   = zw ? bus.imem_req : ack_man;
    assign bus.imem_rdata = bus.imem_addr ^ KEY;

    riscv_fetch_ctrl #(
        .WORD_LENGTH (32),
        .PC_OFFSET   (4),
        .RESET_VECTOR(RV)
    ) dut (
        .clk           (clk),
        .x_reset       (x_reset),
        .imem          (bus.master),
        .redirect_valid(redirect_valid),
        .redirect_addr (redirect_addr),
        .stall         (stall),
        .inst_valid    (inst_valid),
        .inst_out      (inst_out),
        .inst_pc       (inst_pc),
        .inst_pc_plus4 (inst_pc_plus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model state
    logic [31:0] q[$];
    logic [31:0] exp_pc;
    logic        stale;
    logic        idle;
    logic        p_ok, p_req, p_ack;
    logic [31:0] p_addr;

    initial begin
        exp_pc = RV;
        stale  = 1'b0;
        idle   = 1'b1;
        p_ok   = 1'b0;
        p_req  = 1'b0;
        p_ack  = 1'b0;
        p_addr = '0;
    end

    // Compare process: outputs checked against the model every cycle.
    always @(negedge clk) begin
        if (!x_reset) begin
            q.delete();
            stale  = 1'b0;
            exp_pc = RV;
            idle   = 1'b1;
            p_ok   = 1'b0;
        end else if (idle) begin
            chk("idle_req",   32'(bus.imem_req), 32'd0);
            chk("idle_valid", 32'(inst_valid),   32'd0);
            idle  = 1'b0;
            p_ok  = 1'b1;
            p_req = bus.imem_req;
            p_ack = bus.imem_ack;
            p_addr = bus.imem_addr;
        end else begin
            chk("req_rule",   32'(bus.imem_req), 32'(q.size() < 2));
            chk("valid_rule", 32'(inst_valid),   32'(q.size() > 0));
            if (bus.imem_req && !stale)
                chk("fetch_addr", bus.imem_addr, exp_pc);
            if (inst_valid && q.size() > 0) begin
                chk("inst_pc",    inst_pc,       q[0]);
                chk("inst_out",   inst_out,      q[0] ^ KEY);
                chk("inst_pc_p4", inst_pc_plus4, q[0] + 32'd4);
            end
            if (p_ok && p_req && !p_ack) begin
                chk("hold_req",  32'(bus.imem_req), 32'd1);
                chk("hold_addr", bus.imem_addr,     p_addr);
            end
            // Advance the model by this cycle's events.
            if (redirect_valid) begin
                q.delete();
                exp_pc = {redirect_addr[31:2], 2'b00};
                if (bus.imem_req && !bus.imem_ack) stale = 1'b1;
                else if (bus.imem_req && bus.imem_ack) stale = 1'b0;
            end else begin
                if (inst_valid && !stall && q.size() > 0) void'(q.pop_front());
                if (bus.imem_req && bus.imem_ack) begin
                    if (stale) begin
                        stale = 1'b0;
                    end else begin
                        q.push_back(exp_pc);
                        exp_pc = exp_pc + 32'd4;
                    end
                end
            end
            p_ok   = 1'b1;
            p_req  = bus.imem_req;
            p_ack  = bus.imem_ack;
            p_addr = bus.imem_addr;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [15:0] pat;

    // Directed stimulus with hand-computed literal expectations.
    initial begin
        x_reset        = 1'b1;
        redirect_valid = 1'b0;
        redirect_addr  = '0;
        stall          = 1'b0;
        zw             = 1'b1;
        ack_man        = 1'b0;
        #1 x_reset = 1'b0;
        #1;
        chk("rst_req",   32'(bus.imem_req), 32'd0);
        chk("rst_addr",  bus.imem_addr,     RV);
        chk("rst_valid", 32'(inst_valid),   32'd0);
        chk("rst_inst",  inst_out,          32'd0);
        chk("rst_pc",    inst_pc,           32'd0);
        step(2);
        x_reset = 1'b1;

        // Streaming with zero-wait memory
        step(1);
        chk("t1_req0",   32'(bus.imem_req), 32'd1);
        chk("t1_addr0",  bus.imem_addr,     32'h0);
        chk("t1_vld0",   32'(inst_valid),   32'd0);
        step(1);
        chk("t1_pc0",    inst_pc,           32'h0);
        chk("t1_addr4",  bus.imem_addr,     32'h4);
        chk("t1_p4",     inst_pc_plus4,     32'h4);
        step(1);
        chk("t1_pc4",    inst_pc,           32'h4);
        chk("t1_inst4",  inst_out,          32'hA5A5A5A1);
        step(1);
        chk("t1_pc8",    inst_pc,           32'h8);

        // Stall three cycles with inst_pc=0x8
        stall = 1'b1;
        step(1);
        chk("t2_req_skid", 32'(bus.imem_req), 32'd0);
        chk("t2_pc_hold",  inst_pc,           32'h8);
        step(2);
        stall = 1'b0;
        chk("t2_pc_hold3", inst_pc,           32'h8);
        step(1);
        chk("t2_pc_c",     inst_pc,           32'hC);
        chk("t2_addr10",   bus.imem_addr,     32'h10);
        step(1);
        chk("t2_pc_10",    inst_pc,           32'h10);
        chk("t2_addr14",   bus.imem_addr,     32'h14);

        // Redirect while a request waits for its ack
        zw = 1'b0;
        step(1);
        chk("t3_vld0",  32'(inst_valid),   32'd0);
        chk("t3_addr",  bus.imem_addr,     32'h14);
        redirect_valid = 1'b1;
        redirect_addr  = 32'h100;
        step(1);
        redirect_valid = 1'b0;
        ack_man        = 1'b1;
        chk("t3_drain_req",  32'(bus.imem_req), 32'd1);
        chk("t3_drain_addr", bus.imem_addr,     32'h14);
        step(1);
        zw      = 1'b1;
        ack_man = 1'b0;
        chk("t3_tgt_addr", bus.imem_addr,   32'h100);
        chk("t3_tgt_vld",  32'(inst_valid), 32'd0);
        step(1);
        chk("t3_pc100",    inst_pc,         32'h100);

        // Redirect in the same cycle as an ack, unaligned target
        redirect_valid = 1'b1;
        redirect_addr  = 32'h203;
        step(1);
        redirect_valid = 1'b0;
        chk("t4_addr200", bus.imem_addr,     32'h200);
        chk("t4_req",     32'(bus.imem_req), 32'd1);
        chk("t4_vld0",    32'(inst_valid),   32'd0);
        step(1);
        chk("t4_pc200",   inst_pc,           32'h200);

        // Redirect with output stalled and skid full
        stall = 1'b1;
        step(1);
        chk("t5_req_skid", 32'(bus.imem_req), 32'd0);
        redirect_valid = 1'b1;
        redirect_addr  = 32'h40;
        step(1);
        redirect_valid = 1'b0;
        stall          = 1'b0;
        chk("t5_vld0",    32'(inst_valid), 32'd0);
        chk("t5_addr40",  bus.imem_addr,   32'h40);
        step(1);
        chk("t5_pc40",    inst_pc,         32'h40);
        step(1);
        chk("t5_pc44",    inst_pc,         32'h44);

        // Asynchronous reset during a wait, then PC wrap-around
        zw = 1'b0;
        step(1);
        chk("t6_wait_req", 32'(bus.imem_req), 32'd1);
        #2 x_reset = 1'b0;
        #1;
        chk("t6_async_req",  32'(bus.imem_req), 32'd0);
        chk("t6_async_addr", bus.imem_addr,     RV);
        chk("t6_async_vld",  32'(inst_valid),   32'd0);
        step(1);
        x_reset = 1'b1;
        zw      = 1'b1;
        step(1);
        redirect_valid = 1'b1;
        redirect_addr  = 32'hFFFFFFFC;
        step(1);
        redirect_valid = 1'b0;
        chk("t6_addr_top", bus.imem_addr, 32'hFFFFFFFC);
        step(1);
        chk("t6_pc_top",   inst_pc,       32'hFFFFFFFC);
        chk("t6_p4_wrap",  inst_pc_plus4, 32'h0);
        chk("t6_inst_top", inst_out,      32'h5A5A5A59);
        chk("t6_addr_wrap", bus.imem_addr, 32'h0);
        step(1);
        chk("t6_pc_wrap",  inst_pc,       32'h0);
        chk("t6_addr4",    bus.imem_addr, 32'h4);

        // Mixed stall pattern checked by the model
        pat = 16'b0110_0011_1000_1101;
        for (int i = 0; i < 16; i++) begin
            stall = pat[i];
            step(1);
        end
        stall = 1'b0;
        step(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
